instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter BITSIZE, default 32: address/data width of the core.
REQ-002 SHALL have parameter DEPTH, default 256: number of 32-bit instruction words.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request accept to response valid, legal range 1..15.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is clocked on the rising edge.
REQ-005 SHALL have port reset_i, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port IF_MEM_give_i, input, 1: fetch request valid.
REQ-007 SHALL have port MEM_IF_get_o, output, 1: responder accepts the request this cycle.
REQ-008 SHALL have port IF_MEM_addr_i, input, BITSIZE: byte address of the fetch.
REQ-009 SHALL have port MEM_IF_give_o, output, 1: response valid.
REQ-010 SHALL have port IF_MEM_get_i, input, 1: IF consumes the response this cycle.
REQ-011 SHALL have port MEM_IF_instr_o, output, 32: fetched instruction word.
REQ-012 SHALL have port MEM_IF_err_o, output, 1: fetch fault, valid only while MEM_IF_give_o is high.
REQ-013 SHALL have port load_en_i, input, 1: backdoor word write strobe.
REQ-014 SHALL have port load_addr_i, input, BITSIZE: byte address of the backdoor write.
REQ-015 SHALL have port load_data_i, input, 32: backdoor write data.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-017 IDLE: MEM_IF_get_o SHALL be 1; IF_MEM_give_i=1 SHALL latch the address and move to WAIT, or to RESP directly if LATENCY=1.
REQ-018 WAIT: the latency counter SHALL be loaded with LATENCY-2 on accept and decrement each cycle; at 0 the FSM SHALL move to RESP; MEM_IF_get_o SHALL be 0.
REQ-019 The array SHALL be read on the cycle the FSM enters RESP, so MEM_IF_give_o rises exactly LATENCY cycles after the accept edge.
REQ-020 RESP: MEM_IF_give_o=1 and MEM_IF_instr_o/MEM_IF_err_o SHALL hold stable until IF_MEM_get_i=1; IF_MEM_get_i=1 SHALL return the FSM to IDLE the next cycle.
REQ-021 MEM_IF_get_o SHALL be 0 outside IDLE, including the cycle in which RESP is consumed; minimum request spacing is LATENCY+1 cycles.
REQ-022 IF_MEM_addr_i[1:0]!=0 SHALL produce err=1 and instr=0.
REQ-023 A word index IF_MEM_addr_i[BITSIZE-1:2] >= DEPTH SHALL produce err=1 and instr=0.
REQ-024 Changes to IF_MEM_addr_i after accept SHALL have no effect on the response.
REQ-025 MEM_IF_instr_o and MEM_IF_err_o SHALL be 0 whenever MEM_IF_give_o=0.
REQ-026 A load write SHALL take effect at the clock edge, in any FSM state, independent of the fetch handshake.
REQ-027 A load write to an unaligned or out-of-range address SHALL be ignored.
REQ-028 A load write to the same word in the same cycle as the array read SHALL return old data (read-before-write).
REQ-029 IF_MEM_get_i while not in RESP SHALL be ignored.

Reset
REQ-030 reset_i=1 at a clock edge SHALL force the FSM to IDLE and clear the counter and latched address.
REQ-031 During reset, get_o SHALL be 0 and give_o, instr_o and err_o SHALL be 0; get_o SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset mid-transaction (WAIT or RESP) SHALL drop the pending response without a give pulse.
REQ-033 Array contents SHALL NOT be reset.
REQ-034 reset_i SHALL take priority over load_en_i in the same cycle, and that write SHALL be dropped.

Structure
REQ-035 The state enum mem_state_t and the constant INSTR_NOP = 32'h0000_0013 SHALL live in the shared core_pkg.
REQ-036 Storage SHALL be one sub-module, instr_mem_array: DEPTH x 32, one synchronous write port and one read port.
REQ-037 The FSM, counter and fault checks SHALL stay in instr_mem_responder.

Verification
REQ-038 Load word 0 = 32'h00500093; fetch addr 0 with LATENCY=2 and IF_MEM_get_i held 1 -> give_o rises 2 cycles after accept, instr=32'h00500093, err=0, get_o back at 1 two cycles later.
REQ-039 Fetch addr 4 with IF_MEM_get_i held 0 for 5 cycles -> give_o stays 1 and instr stays stable for 5 cycles; get_o=0 throughout.
REQ-040 Fetch addr 32'h2 and, separately, addr 4*DEPTH -> err=1 and instr=0, each for exactly one handshake.
REQ-041 Assert reset_i in the cycle after accepting addr 8 -> give_o never rises, and get_o=1 in the first cycle after reset deasserts.
REQ-042 load_en_i to word 3 in the cycle the FSM enters RESP for addr 12 -> old data returned; a refetch of addr 12 returns the new data.
REQ-043 Run with LATENCY=1 and back-to-back requests -> accepts spaced exactly 2 cycles apart.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared fetch-path types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam int unsigned LAT_CNT_W = 4;
  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_array
// Description : DEPTH x 32 word store, one synchronous write, one registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read samples the array before this edge's write lands (read-before-write).
  always_comb begin
    rdata_d = rdata_q;
    if (re_i && (32'(raddr_i) < 32'(DEPTH))) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder
// Description : Single-outstanding instruction fetch responder with fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_responder
  import core_pkg::*;
#(
  parameter int BITSIZE = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               IF_MEM_give_i,
  output logic               MEM_IF_get_o,
  input  logic [BITSIZE-1:0] IF_MEM_addr_i,
  output logic               MEM_IF_give_o,
  input  logic               IF_MEM_get_i,
  output logic [31:0]        MEM_IF_instr_o,
  output logic               MEM_IF_err_o,
  input  logic               load_en_i,
  input  logic [BITSIZE-1:0] load_addr_i,
  input  logic [31:0]        load_data_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam lat_cnt_t CNT_LOAD = (LATENCY >= 2) ? lat_cnt_t'(LATENCY - 2) : '0;
  localparam logic [BITSIZE-1:0] DEPTH_W = BITSIZE'(DEPTH);

  function automatic logic addr_ok(input logic [BITSIZE-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH_W);
  endfunction

  mem_state_t         state_q, state_d;
  lat_cnt_t           cnt_q, cnt_d;
  logic [BITSIZE-1:0] addr_q, addr_d;
  logic               err_q, err_d;
  logic               rd_en;
  logic [AW-1:0]      rd_index;
  logic               wr_en;
  logic [31:0]        rd_data;
  logic               resp_active;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    err_d    = err_q;
    rd_en    = 1'b0;
    rd_index = addr_q[AW+1:2];
    case (state_q)
      MEM_IDLE: begin
        if (IF_MEM_give_i) begin
          addr_d = IF_MEM_addr_i;
          if (LATENCY == 1) begin
            // Single-cycle latency reads straight from the incoming address.
            state_d  = MEM_RESP;
            rd_en    = 1'b1;
            rd_index = IF_MEM_addr_i[AW+1:2];
            err_d    = !addr_ok(IF_MEM_addr_i);
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = MEM_RESP;
          rd_en   = 1'b1;
          err_d   = !addr_ok(addr_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MEM_RESP: begin
        if (IF_MEM_get_i) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Reset wins over the backdoor write; bad addresses are silently dropped.
  assign wr_en = load_en_i && !reset_i && addr_ok(load_addr_i);

  instr_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (load_addr_i[AW+1:2]),
    .wdata_i (load_data_i),
    .re_i    (rd_en),
    .raddr_i (rd_index),
    .rdata_o (rd_data)
  );

  assign resp_active    = (state_q == MEM_RESP) && !reset_i;
  assign MEM_IF_get_o   = (state_q == MEM_IDLE) && !reset_i;
  assign MEM_IF_give_o  = resp_active;
  assign MEM_IF_err_o   = resp_active && err_q;
  assign MEM_IF_instr_o = (resp_active && !err_q) ? rd_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_responder
// Description : Directed self-checking bench, LATENCY=2 and LATENCY=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        give, get, load_en;
  logic [31:0] addr, load_addr, load_data;
  logic        get_o, give_o, err_o;
  logic [31:0] instr_o;
  logic        give1, get1;
  logic [31:0] addr1;
  logic        get_o1, give_o1, err_o1;
  logic [31:0] instr_o1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.BITSIZE(32), .DEPTH(256), .LATENCY(2)) dut (
    .clk            (clk),
    .reset_i        (rst),
    .IF_MEM_give_i  (give),
    .MEM_IF_get_o   (get_o),
    .IF_MEM_addr_i  (addr),
    .MEM_IF_give_o  (give_o),
    .IF_MEM_get_i   (get),
    .MEM_IF_instr_o (instr_o),
    .MEM_IF_err_o   (err_o),
    .load_en_i      (load_en),
    .load_addr_i    (load_addr),
    .load_data_i    (load_data)
  );

  instr_mem_responder #(.BITSIZE(32), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk            (clk),
    .reset_i        (rst),
    .IF_MEM_give_i  (give1),
    .MEM_IF_get_o   (get_o1),
    .IF_MEM_addr_i  (addr1),
    .MEM_IF_give_o  (give_o1),
    .IF_MEM_get_i   (get1),
    .MEM_IF_instr_o (instr_o1),
    .MEM_IF_err_o   (err_o1),
    .load_en_i      (load_en),
    .load_addr_i    (load_addr),
    .load_data_i    (load_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  // Fetch with IF_MEM_get_i held high: response in cycle 2, idle again in cycle 3.
  task automatic fetch_expect(input string tag, input logic [31:0] a,
                              input logic [31:0] exp_instr, input logic exp_err);
    chk({tag, "_ready"}, 32'(get_o), 32'd1);
    give = 1'b1;
    addr = a;
    step();
    give = 1'b0;
    step();
    chk({tag, "_give"}, 32'(give_o), 32'd1);
    chk({tag, "_instr"}, instr_o, exp_instr);
    chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
    step();
    chk({tag, "_give_end"}, 32'(give_o), 32'd0);
    chk({tag, "_err_end"}, 32'(err_o), 32'd0);
    chk({tag, "_get_end"}, 32'(get_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1; give = 1'b0; get = 1'b0; addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    give1 = 1'b0; get1 = 1'b0; addr1 = '0;
    step();
    step();
    chk("rst_get", 32'(get_o), 32'd0);
    chk("rst_give", 32'(give_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_get_l1", 32'(get_o1), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_get", 32'(get_o), 32'd1);

    load(32'd0, 32'h0050_0093);
    load(32'd4, 32'h00a0_0113);
    load(32'd12, 32'h1111_1111);
    load(32'd20, 32'hAAAA_AAAA);
    load(32'd2, 32'hDEAD_BEEF);
    load(32'd1024, 32'hCAFE_BABE);

    // write in a reset cycle must be dropped
    rst = 1'b1; load_en = 1'b1; load_addr = 32'd20; load_data = 32'hBBBB_BBBB;
    step();
    rst = 1'b0; load_en = 1'b0;
    step();
    chk("rst2_get", 32'(get_o), 32'd1);

    // basic fetch, address changed after accept
    get = 1'b1; give = 1'b1; addr = 32'd0;
    step();
    give = 1'b0; addr = 32'd4;
    chk("f0_wait_get", 32'(get_o), 32'd0);
    chk("f0_wait_give", 32'(give_o), 32'd0);
    chk("f0_wait_instr", instr_o, 32'd0);
    step();
    chk("f0_give", 32'(give_o), 32'd1);
    chk("f0_instr", instr_o, 32'h0050_0093);
    chk("f0_err", 32'(err_o), 32'd0);
    chk("f0_resp_get", 32'(get_o), 32'd0);
    step();
    chk("f0_end_give", 32'(give_o), 32'd0);
    chk("f0_end_instr", instr_o, 32'd0);
    chk("f0_end_get", 32'(get_o), 32'd1);

    // response held while IF stalls
    get = 1'b0; give = 1'b1; addr = 32'd4;
    step();
    give = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step();
      chk("hold_give", 32'(give_o), 32'd1);
      chk("hold_instr", instr_o, 32'h00a0_0113);
      chk("hold_get", 32'(get_o), 32'd0);
    end
    get = 1'b1;
    step();
    chk("hold_end_give", 32'(give_o), 32'd0);
    chk("hold_end_get", 32'(get_o), 32'd1);

    fetch_expect("unaligned", 32'h2, 32'h0, 1'b1);
    fetch_expect("oob", 32'd1024, 32'h0, 1'b1);
    fetch_expect("word5", 32'd20, 32'hAAAA_AAAA, 1'b0);

    // reset while waiting
    give = 1'b1; addr = 32'd8;
    step();
    give = 1'b0; rst = 1'b1;
    step();
    chk("midrst_give", 32'(give_o), 32'd0);
    chk("midrst_get", 32'(get_o), 32'd0);
    rst = 1'b0;
    step();
    chk("midrst_after_give", 32'(give_o), 32'd0);
    chk("midrst_after_get", 32'(get_o), 32'd1);
    step();
    chk("midrst_later_give", 32'(give_o), 32'd0);

    // write to the word being read on the RESP-entry edge
    give = 1'b1; addr = 32'd12;
    step();
    give = 1'b0;
    load_en = 1'b1; load_addr = 32'd12; load_data = 32'h2222_2222;
    step();
    load_en = 1'b0;
    chk("rbw_give", 32'(give_o), 32'd1);
    chk("rbw_instr", instr_o, 32'h1111_1111);
    step();
    fetch_expect("refetch", 32'd12, 32'h2222_2222, 1'b0);

    // LATENCY=1 back-to-back: accept every second cycle
    get1 = 1'b1; give1 = 1'b1; addr1 = 32'd0;
    chk("l1_ready", 32'(get_o1), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i % 2 == 1) begin
        chk("l1_give", 32'(give_o1), 32'd1);
        chk("l1_busy_get", 32'(get_o1), 32'd0);
        chk("l1_instr", instr_o1, 32'h0050_0093);
      end else begin
        chk("l1_idle_give", 32'(give_o1), 32'd0);
        chk("l1_accept_get", 32'(get_o1), 32'd1);
      end
    end
    give1 = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
